// File: rtl/ws_systolic_engine_if.sv
// Streaming bus for the weight-stationary systolic engine.
//   w_valid/w_ready/w_in_vec : weight row handshake (one row per beat)
//   a_valid/a_ready/a_in_vec : activation vector handshake
//   ps_valid/ps_out_vec      : result strobe and data (no backpressure)
//   busy                     : engine is loading weights or has vectors in flight
// master = traffic source (driver of w_* / a_*), slave = the engine.
interface ws_systolic_engine_if #(
    parameter int WORDWIDTH = 8,
    parameter int ARRHEIGHT = 4,
    parameter int ARRWIDTH  = 4,
    parameter int PSWIDTH   = 4 * WORDWIDTH
);
    logic                          w_valid;
    logic                          w_ready;
    logic [WORDWIDTH*ARRWIDTH-1:0] w_in_vec;
    logic                          a_valid;
    logic                          a_ready;
    logic [WORDWIDTH*ARRHEIGHT-1:0] a_in_vec;
    logic                          ps_valid;
    logic [PSWIDTH*ARRWIDTH-1:0]   ps_out_vec;
    logic                          busy;

    modport master (
        output w_valid, w_in_vec, a_valid, a_in_vec,
        input  w_ready, a_ready, ps_valid, ps_out_vec, busy
    );

    modport slave (
        input  w_valid, w_in_vec, a_valid, a_in_vec,
        output w_ready, a_ready, ps_valid, ps_out_vec, busy
    );
endinterface

// File: rtl/ws_systolic_engine.sv
// Weight-stationary systolic MAC engine.
// A weight set (ARRHEIGHT rows of ARRWIDTH signed words) is loaded one row per beat and then
// stays resident. Each accepted activation vector a produces ps[j] = sum_i a[i]*W[i][j]
// exactly ARRHEIGHT+ARRWIDTH clock edges after acceptance, one vector per cycle.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   clear   : synchronous flush of weights, pipeline and in-flight count
//   bus     : ws_systolic_engine_if.slave (weight / activation / result streams, busy)
module ws_systolic_engine #(
    parameter int unsigned WORDWIDTH = 8,
    parameter int unsigned ARRHEIGHT = 4,
    parameter int unsigned ARRWIDTH  = 4,
    parameter int unsigned PSWIDTH   = 4 * WORDWIDTH
) (
    input logic                 clk,
    input logic                 reset_n,
    input logic                 clear,
    ws_systolic_engine_if.slave bus
);

    localparam int          Rows   = int'(ARRHEIGHT);
    localparam int          Cols   = int'(ARRWIDTH);
    localparam int unsigned Lat    = ARRHEIGHT + ARRWIDTH;
    localparam int unsigned CntW   = $clog2(Lat + 1);
    localparam int unsigned RowW   = (ARRHEIGHT > 1) ? $clog2(ARRHEIGHT) : 1;
    localparam int unsigned ProdW  = 2 * WORDWIDTH;
    localparam logic [RowW-1:0] LastRow = RowW'(ARRHEIGHT - 1);

    typedef enum logic [1:0] {
        StEmpty,
        StLoad,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [RowW-1:0]        row_q, row_d;
    logic [CntW-1:0]        inflight_q, inflight_d;

    logic signed [WORDWIDTH-1:0] w_q    [ARRHEIGHT][ARRWIDTH];
    // skew_q[i][k]: row i activation delayed k+1 cycles; tap at k=i
    logic signed [WORDWIDTH-1:0] skew_q [ARRHEIGHT][ARRHEIGHT];
    logic signed [WORDWIDTH-1:0] a_q    [ARRHEIGHT][ARRWIDTH];
    logic signed [PSWIDTH-1:0]   ps_q   [ARRHEIGHT][ARRWIDTH];
    // desk_q[j][k]: bottom of column j delayed k+1 cycles; tap at k=ARRWIDTH-2-j
    logic signed [PSWIDTH-1:0]   desk_q [ARRWIDTH][ARRWIDTH];
    logic [Lat:0]                vld_q;
    logic [PSWIDTH*ARRWIDTH-1:0] ps_out_q;

    logic signed [WORDWIDTH-1:0] a_lane [ARRHEIGHT];
    logic signed [WORDWIDTH-1:0] w_lane [ARRWIDTH];
    logic signed [WORDWIDTH-1:0] a_pe   [ARRHEIGHT][ARRWIDTH];
    logic signed [ProdW-1:0]     prod   [ARRHEIGHT][ARRWIDTH];
    logic signed [PSWIDTH-1:0]   mac_d  [ARRHEIGHT][ARRWIDTH];
    logic [PSWIDTH*ARRWIDTH-1:0] col_vec;

    logic            w_rdy, a_rdy;
    logic            w_fire, a_fire, emit;
    logic [RowW-1:0] wr_row;

    // Handshake readiness. In RUN a reload waits for an empty pipeline and loses to activations.
    always_comb begin
        w_rdy = 1'b1;
        a_rdy = 1'b0;
        if (state_q == StRun) begin
            a_rdy = 1'b1;
            w_rdy = (inflight_q == '0) && !bus.a_valid;
        end
    end

    assign w_fire = bus.w_valid && w_rdy && !clear;
    assign a_fire = bus.a_valid && a_rdy && !clear;
    assign emit   = vld_q[Lat-1];
    assign wr_row = (state_q == StLoad) ? row_q : '0;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        if (clear) begin
            state_d = StEmpty;
            row_d   = '0;
        end else if (w_fire) begin
            unique case (state_q)
                StLoad: begin
                    if (row_q == LastRow) begin
                        state_d = StRun;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RowW'(1);
                    end
                end
                default: begin
                    // First row of a new set (from EMPTY or RUN)
                    if (ARRHEIGHT == 1) begin
                        state_d = StRun;
                        row_d   = '0;
                    end else begin
                        state_d = StLoad;
                        row_d   = RowW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (clear) begin
            inflight_d = '0;
        end else if (a_fire && !emit) begin
            inflight_d = inflight_q + CntW'(1);
        end else if (!a_fire && emit) begin
            inflight_d = inflight_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StEmpty;
            row_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        for (int i = 0; i < Rows; i++) begin
            a_lane[i] = bus.a_in_vec[i*WORDWIDTH +: WORDWIDTH];
        end
        for (int j = 0; j < Cols; j++) begin
            w_lane[j] = bus.w_in_vec[j*WORDWIDTH +: WORDWIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_q <= '{default: '0};
        end else if (clear) begin
            w_q <= '{default: '0};
        end else if (w_fire) begin
            for (int j = 0; j < Cols; j++) begin
                w_q[wr_row][j] <= w_lane[j];
            end
        end
    end

    // PE array: activations move right, partial sums move down, one hop per cycle.
    always_comb begin
        a_pe  = '{default: '0};
        prod  = '{default: '0};
        mac_d = '{default: '0};
        for (int i = 0; i < Rows; i++) begin
            a_pe[i][0] = skew_q[i][i];
            for (int j = 1; j < Cols; j++) begin
                a_pe[i][j] = a_q[i][j-1];
            end
        end
        for (int i = 0; i < Rows; i++) begin
            for (int j = 0; j < Cols; j++) begin
                prod[i][j] = ProdW'(a_pe[i][j]) * ProdW'(w_q[i][j]);
            end
        end
        for (int j = 0; j < Cols; j++) begin
            mac_d[0][j] = PSWIDTH'(prod[0][j]);
            for (int i = 1; i < Rows; i++) begin
                mac_d[i][j] = ps_q[i-1][j] + PSWIDTH'(prod[i][j]);
            end
        end
    end

    always_comb begin
        col_vec = '0;
        for (int j = 0; j < Cols - 1; j++) begin
            col_vec[j*PSWIDTH +: PSWIDTH] = desk_q[j][Cols-2-j];
        end
        col_vec[(Cols-1)*PSWIDTH +: PSWIDTH] = ps_q[Rows-1][Cols-1];
    end

    // Idle cycles inject zeros so unused wavefronts never carry stale data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skew_q <= '{default: '0};
            a_q    <= '{default: '0};
            ps_q   <= '{default: '0};
            desk_q <= '{default: '0};
            vld_q  <= '0;
        end else if (clear) begin
            skew_q <= '{default: '0};
            a_q    <= '{default: '0};
            ps_q   <= '{default: '0};
            desk_q <= '{default: '0};
            vld_q  <= '0;
        end else begin
            for (int i = 0; i < Rows; i++) begin
                skew_q[i][0] <= a_fire ? a_lane[i] : '0;
                for (int k = 1; k <= i; k++) begin
                    skew_q[i][k] <= skew_q[i][k-1];
                end
            end
            a_q  <= a_pe;
            ps_q <= mac_d;
            for (int j = 0; j < Cols - 1; j++) begin
                desk_q[j][0] <= ps_q[Rows-1][j];
                for (int k = 1; k < Cols - 1 - j; k++) begin
                    desk_q[j][k] <= desk_q[j][k-1];
                end
            end
            vld_q <= {vld_q[Lat-1:0], a_fire};
        end
    end

    // Output register holds its value between results and across clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_out_q <= '0;
        end else if (emit && !clear) begin
            ps_out_q <= col_vec;
        end
    end

    assign bus.w_ready    = w_rdy;
    assign bus.a_ready    = a_rdy;
    assign bus.ps_valid   = vld_q[Lat];
    assign bus.ps_out_vec = ps_out_q;
    assign bus.busy       = (state_q == StLoad) || (inflight_q != '0);

endmodule

// File: tb/tb_ws_systolic_engine.sv
// Scoreboard bench for ws_systolic_engine (4x4, 8-bit words, 32-bit sums).
module tb_ws_systolic_engine;

    localparam int WW = 8;
    localparam int H  = 4;
    localparam int WD = 4;
    localparam int PS = 32;
    localparam int L  = H + WD;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic clear   = 1'b0;

    always #5 clk = ~clk;

    ws_systolic_engine_if #(
        .WORDWIDTH(WW), .ARRHEIGHT(H), .ARRWIDTH(WD), .PSWIDTH(PS)
    ) bus ();

    ws_systolic_engine #(
        .WORDWIDTH(WW), .ARRHEIGHT(H), .ARRWIDTH(WD), .PSWIDTH(PS)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (clear),
        .bus    (bus)
    );

    typedef struct {
        logic [PS*WD-1:0] data;
        int               due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference weight store and load position
    logic signed [WW-1:0] wm [H][WD];
    int                   wrow;
    bit                   ovr_en = 1'b0;
    logic [PS*WD-1:0]     ovr_data;

    bit d_wf, d_af, d_wr, d_ar;
    int d_e;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [PS*WD-1:0] act,
                        input logic [PS*WD-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [WW*4-1:0] pk(input int e0, input int e1, input int e2,
                                           input int e3);
        logic [WW*4-1:0] v;
        v = {e3[WW-1:0], e2[WW-1:0], e1[WW-1:0], e0[WW-1:0]};
        return v;
    endfunction

    function automatic logic [PS*4-1:0] pks(input int e0, input int e1, input int e2,
                                            input int e3);
        logic [PS*4-1:0] v;
        v = {e3, e2, e1, e0};
        return v;
    endfunction

    // ps[j] = sum_i a[i]*W[i][j], modulo 2^PS
    function automatic logic [PS*WD-1:0] model(input logic [WW*H-1:0] a);
        logic [PS*WD-1:0] r;
        logic [PS-1:0]    acc;
        longint           p;
        logic signed [WW-1:0] ai;
        r = '0;
        for (int j = 0; j < WD; j++) begin
            acc = '0;
            for (int i = 0; i < H; i++) begin
                ai  = a[i*WW +: WW];
                p   = longint'(ai) * longint'(wm[i][j]);
                acc = acc + PS'(p);
            end
            r[j*PS +: PS] = acc;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < H; i++)
            for (int j = 0; j < WD; j++) wm[i][j] = '0;
        wrow = 0;
    endtask

    // One clock cycle of stimulus; edge_n is the number of the edge that samples it.
    task automatic step(input bit wv, input logic [WW*WD-1:0] wd, input bit av,
                        input logic [WW*H-1:0] ad, input bit clr, output bit wf,
                        output bit af, output bit wr, output bit ar, output int edge_n);
        exp_t e;
        int   r;
        @(negedge clk);
        bus.w_valid  = wv;
        bus.w_in_vec = wd;
        bus.a_valid  = av;
        bus.a_in_vec = ad;
        clear        = clr;
        #1;
        wr     = bus.w_ready;
        ar     = bus.a_ready;
        wf     = wv && wr && !clr;
        af     = av && ar && !clr;
        edge_n = cyc + 1;
        if (af) begin
            e.data = ovr_en ? ovr_data : model(ad);
            e.due  = edge_n + L;
            q.push_back(e);
        end
        if (wf) begin
            if (wrow == 0 || wrow == H) begin
                r    = 0;
                wrow = 1;
            end else begin
                r    = wrow;
                wrow = wrow + 1;
            end
            for (int j = 0; j < WD; j++) wm[r][j] = wd[j*WW +: WW];
        end
        @(posedge clk);
        if (clr) begin
            q.delete();
            model_reset();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0, 1'b0, d_wf, d_af, d_wr, d_ar, d_e);
    endtask

    task automatic load_row(input logic [WW*WD-1:0] wd);
        bit wf;
        int n;
        n  = 0;
        wf = 1'b0;
        while (!wf && n < 20) begin
            step(1'b1, wd, 1'b0, '0, 1'b0, wf, d_af, d_wr, d_ar, d_e);
            n++;
        end
        if (!wf) chk("load_timeout", 0, 1);
    endtask

    task automatic send_a(input logic [WW*H-1:0] ad);
        bit af;
        step(1'b0, '0, 1'b1, ad, 1'b0, d_wf, af, d_wr, d_ar, d_e);
        chk("a_accept", longint'(af), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            idle(1);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", longint'(q.size()), 0);
    endtask

    task automatic load_pattern();
        load_row(pk(1, 2, 3, 4));
        load_row(pk(4, 3, 2, 1));
        load_row(pk(1, 2, 3, 4));
        load_row(pk(4, 3, 2, 1));
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_busy"}, longint'(bus.busy), 0);
        chk({tag, "_a_ready"}, longint'(bus.a_ready), 0);
        chk({tag, "_w_ready"}, longint'(bus.w_ready), 1);
    endtask

    // Monitor: pops one expectation per ps_valid, checks data, latency and hold.
    initial begin
        exp_t             e;
        logic [PS*WD-1:0] last;
        last = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last = '0;
            end else if (bus.ps_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_ps_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chkv("ps_data", bus.ps_out_vec, e.data);
                    chk("ps_latency", longint'(cyc), longint'(e.due));
                end
                last = bus.ps_out_vec;
            end else begin
                chkv("ps_hold", bus.ps_out_vec, last);
            end
        end
    end

    initial begin
        bit wf, af, wr, ar;
        int e_acc, e_w, n;
        logic [WW*H-1:0] ra;
        bus.w_valid  = 1'b0;
        bus.w_in_vec = '0;
        bus.a_valid  = 1'b0;
        bus.a_in_vec = '0;
        model_reset();
        #1 reset_n = 1'b0;
        #2;
        chk("rst_w_ready", longint'(bus.w_ready), 1);
        chk("rst_a_ready", longint'(bus.a_ready), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_ps_valid", longint'(bus.ps_valid), 0);
        chkv("rst_ps_out", bus.ps_out_vec, '0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Basic MAC
        load_row(pk(1, 2, 3, 4));
        step(1'b0, '0, 1'b1, pk(1, 1, 1, 1), 1'b0, wf, af, wr, ar, e_acc);
        chk("load_a_ready", longint'(ar), 0);
        chk("load_busy", longint'(bus.busy), 1);
        load_row(pk(4, 3, 2, 1));
        load_row(pk(1, 2, 3, 4));
        load_row(pk(4, 3, 2, 1));
        ovr_en   = 1'b1;
        ovr_data = pks(28, 26, 24, 22);
        send_a(pk(1, 2, 3, 4));
        ovr_en = 1'b0;
        drain();

        // Back-to-back streaming
        ovr_en   = 1'b1;
        ovr_data = pks(28, 26, 24, 22);
        send_a(pk(1, 2, 3, 4));
        ovr_data = pks(22, 24, 26, 28);
        send_a(pk(4, 3, 2, 1));
        ovr_en = 1'b0;
        drain();

        // Signed wrap: (-1)*(-128) summed over four rows
        repeat (H) load_row(pk(255, 255, 255, 255));
        ovr_en   = 1'b1;
        ovr_data = pks(32'h200, 32'h200, 32'h200, 32'h200);
        send_a(pk(128, 128, 128, 128));
        ovr_en = 1'b0;
        drain();

        // Priority: weight beat loses to activation while idle in RUN
        load_pattern();
        ovr_en   = 1'b1;
        ovr_data = pks(28, 26, 24, 22);
        step(1'b1, pk(9, 9, 9, 9), 1'b1, pk(1, 2, 3, 4), 1'b0, wf, af, wr, ar, e_acc);
        chk("prio_w_ready", longint'(wr), 0);
        chk("prio_a_ready", longint'(ar), 1);
        chk("prio_a_fire", longint'(af), 1);
        ovr_data = pks(22, 24, 26, 28);
        send_a(pk(4, 3, 2, 1));
        ovr_en = 1'b0;
        drain();

        // Reload gating: beat offered two cycles after an accept waits for the result
        step(1'b0, '0, 1'b1, 32'($urandom()), 1'b0, wf, af, wr, ar, e_acc);
        idle(1);
        n  = 0;
        wf = 1'b0;
        while (!wf && n < 30) begin
            step(1'b1, 32'($urandom()), 1'b0, '0, 1'b0, wf, af, wr, ar, e_w);
            n++;
        end
        chk("reload_accepted", longint'(wf), 1);
        chk("reload_edge", longint'(e_w), longint'(e_acc + L + 1));
        step(1'b0, '0, 1'b1, 32'($urandom()), 1'b0, wf, af, wr, ar, e_w);
        chk("reload_a_ready", longint'(ar), 0);
        repeat (H - 1) load_row(32'($urandom()));
        drain();

        // Randomized stream with gaps and competing weight offers
        for (int k = 0; k < 80; k++) begin
            bit av, wv;
            av = ($urandom_range(0, 3) != 0);
            wv = av && ($urandom_range(0, 1) == 1);
            step(wv, 32'($urandom()), av, 32'($urandom()), 1'b0, wf, af, wr, ar, e_w);
            if (wv) chk("rand_w_blocked", longint'(wf), 0);
        end
        drain();
        repeat (H) load_row(32'($urandom()));
        for (int k = 0; k < 40; k++) begin
            step(1'b0, '0, ($urandom_range(0, 1) == 1), 32'($urandom()), 1'b0,
                 wf, af, wr, ar, e_w);
        end
        drain();

        // Clear three cycles after an accept, with a handshake offered in the clear cycle
        send_a(32'($urandom()));
        idle(2);
        step(1'b0, '0, 1'b1, 32'($urandom()), 1'b1, wf, af, wr, ar, e_w);
        idle(14);
        check_quiet("clear");

        // Asynchronous reset mid-flight
        repeat (H) load_row(32'($urandom()));
        send_a(32'($urandom()));
        idle(2);
        @(negedge clk);
        #2 reset_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        chk("mid_rst_w_ready", longint'(bus.w_ready), 1);
        chk("mid_rst_a_ready", longint'(bus.a_ready), 0);
        chk("mid_rst_busy", longint'(bus.busy), 0);
        chk("mid_rst_ps_valid", longint'(bus.ps_valid), 0);
        chkv("mid_rst_ps_out", bus.ps_out_vec, '0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(14);
        check_quiet("reset");

        // Normal operation resumes after reset
        repeat (H) load_row(32'($urandom()));
        ra = 32'($urandom());
        send_a(ra);
        send_a(~ra);
        drain();

        chk("queue_empty", longint'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=0", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ws_systolic_engine.md
WS_SYSTOLIC_ENGINE -- requirements
Module: ws_systolic_engine

Interface
REQ-001 SHALL have parameter WORDWIDTH, default 8: signed weight and activation width.
REQ-002 SHALL have parameter ARRHEIGHT, default 4: PE rows, equal to the activation lanes.
REQ-003 SHALL have parameter ARRWIDTH, default 4: PE columns, equal to the weight and output lanes.
REQ-004 SHALL have parameter PSWIDTH, default 4*WORDWIDTH: partial-sum width.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port clear, input, 1: synchronous flush.
REQ-008 SHALL have port w_valid, input, 1: weight row offered.
REQ-009 SHALL have port w_ready, output, 1: weight row accepted when w_valid is also high.
REQ-010 SHALL have port w_in_vec, input, WORDWIDTH*ARRWIDTH: one weight row; lane j occupies bits [j*WORDWIDTH +: WORDWIDTH].
REQ-011 SHALL have port a_valid, input, 1: activation vector offered.
REQ-012 SHALL have port a_ready, output, 1: activation vector accepted when a_valid is also high.
REQ-013 SHALL have port a_in_vec, input, WORDWIDTH*ARRHEIGHT: activation vector; lane i feeds row i.
REQ-014 SHALL have port ps_valid, output, 1: result strobe; there is no output backpressure.
REQ-015 SHALL have port ps_out_vec, output, PSWIDTH*ARRWIDTH: result vector; lane j is column j.
REQ-016 SHALL have port busy, output, 1: high when state is LOAD or inflight != 0.

Function
REQ-017 SHALL implement FSM states EMPTY (no weights), LOAD (loading weights) and RUN (weights valid).
REQ-018 SHALL, in EMPTY, drive w_ready=1 and a_ready=0; an accepted weight beat SHALL write row 0 and move the FSM to LOAD with row counter=1.
REQ-019 SHALL, in LOAD, drive w_ready=1 and a_ready=0; accepted beat k SHALL write row k; after the beat for row ARRHEIGHT-1 the FSM SHALL go to RUN; gaps in w_valid SHALL hold state.
REQ-020 SHALL, in RUN, drive a_ready=1, w_ready=(inflight==0)&&!a_valid; an accepted weight beat SHALL write row 0 of a new set and move the FSM to LOAD.
REQ-021 SHALL give activation priority when w_valid and a_valid are both high in RUN; the weight beat SHALL NOT be accepted that cycle.
REQ-022 SHALL compute ps[j] = sum over i of a[i]*W[i][j], with signed operands, each product sign-extended to PSWIDTH and the sum wrapping modulo 2^PSWIDTH.
REQ-023 SHALL skew row i internally by i cycles and deskew column j by ARRWIDTH-1-j cycles, so all lanes of one result appear in the same cycle.
REQ-024 SHALL assert ps_valid with the result exactly L = ARRHEIGHT+ARRWIDTH rising edges after the acceptance edge (L=8 for 4x4).
REQ-025 SHALL accept one vector per cycle; back-to-back inputs SHALL yield back-to-back results in order.
REQ-026 SHALL hold ps_out_vec at its last value while ps_valid=0.
REQ-027 SHALL keep inflight (0..L) = accepted minus emitted vectors; simultaneous accept and emit SHALL leave it unchanged.
REQ-028 SHALL, on clear=1, go to EMPTY, zero all weights, the pipeline and inflight, and suppress any pending ps_valid; any handshake in that same cycle SHALL be ignored.
REQ-029 SHALL keep weights unchanged by activity in RUN.

Reset
REQ-030 SHALL, while reset_n=0, immediately force state=EMPTY, weights, pipeline, inflight and ps_out_vec to 0, ps_valid=0, busy=0, a_ready=0, w_ready=1.
REQ-031 SHALL discard in-flight vectors on reset mid-operation and emit no result for them afterwards.

Verification
REQ-032 SHALL pass: basic MAC on 4x4 with weight rows [1,2,3,4],[4,3,2,1],[1,2,3,4],[4,3,2,1] then a=[1,2,3,4] -> 8 cycles later ps_valid=1, ps=[28,26,24,22].
REQ-033 SHALL pass: streaming with a=[1,2,3,4] and a=[4,3,2,1] back-to-back on the same weights -> ps_valid high 2 consecutive cycles, ps=[28,26,24,22] then [22,24,26,28].
REQ-034 SHALL pass: signed wrap with all weights 8'hFF and all a=8'h80 -> every lane 32'h00000200.
REQ-035 SHALL pass: priority with w_valid and a_valid together in RUN, inflight=0 -> activation accepted, weights unchanged, w_ready=0 that cycle.
REQ-036 SHALL pass: reload gating with a weight beat offered 2 cycles after an accept -> w_ready=0 until that result emits, then the beat is accepted, FSM goes to LOAD and a_ready=0.
REQ-037 SHALL pass: reset or clear 3 cycles after an accept -> no ps_valid ever appears, state=EMPTY, busy=0, a_ready=0.
